// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: per-stage ready/flush generation for an N-stage pipeline, with trap/ERET sequencing, stall perf counter and stall watchdog.
// Latency: ready/flush are combinational from stage_valid and hazards; redirect pulses 2 cycles after a trap is accepted.
// Backpressure: stages hold when any stage is not done (prdy=0); younger stages hold and a bubble is inserted on a hazard.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int STALL_STAGE = 2,
    parameter int TRAP_STAGE  = 1,
    parameter int WDOG_LIMIT  = 255,
    parameter int WDOG_WIDTH  = 8,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_flush,
    input  logic                  s_loaduse,
    input  logic                  s_branch_jr_ok,
    input  logic                  s_int,
    input  logic                  s_syscall,
    input  logic                  s_eret,
    output logic                  redirect,
    output logic [1:0]            redirect_cause,
    output logic                  trap_busy,
    output logic [PERF_WIDTH-1:0] stall_cycles,
    output logic                  wdog_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_INT     = 2'b01;
    localparam logic [1:0] CAUSE_SYSCALL = 2'b10;
    localparam logic [1:0] CAUSE_ERET    = 2'b11;

    localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = WDOG_WIDTH'(WDOG_LIMIT);

    state_t                 state_q;
    state_t                 state_d;
    logic [1:0]             cause_q;
    logic [1:0]             cause_d;
    logic [WDOG_WIDTH-1:0]  wdog_cnt_q;

    logic                   prdy;
    logic                   stall;
    logic                   trap;
    logic                   stall_cnt_en;
    logic [NUM_STAGES-1:0]  trap_mask;

    assign prdy  = &stage_valid;
    assign stall = s_loaduse | ~s_branch_jr_ok;
    assign trap  = s_int | s_syscall | s_eret;

    // Stages 0..TRAP_STAGE are the ones squashed by a trap.
    always_comb begin
        trap_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            trap_mask[i] = (i <= TRAP_STAGE);
        end
    end

    // Trap FSM next-state plus the ready/flush/redirect outputs; everything is held low while in reset.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        stage_ready    = '0;
        stage_flush    = '0;
        redirect       = 1'b0;
        redirect_cause = 2'b00;
        trap_busy      = 1'b0;
        stall_cnt_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (trap && prdy) begin
                    // The flush removes the stalling instruction, so hazards are moot here.
                    if (s_int)          cause_d = CAUSE_INT;
                    else if (s_syscall) cause_d = CAUSE_SYSCALL;
                    else                cause_d = CAUSE_ERET;
                    stage_ready = '1;
                    stage_flush = trap_mask;
                    state_d     = FLUSH;
                end else begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_ready[i] = (i < STALL_STAGE) ? (prdy & ~stall) : prdy;
                    end
                    stage_flush[STALL_STAGE] = stall;
                    stall_cnt_en = ~trap & prdy & stall;
                end
            end
            FLUSH: begin
                stage_flush = trap_mask;
                stage_ready = {NUM_STAGES{prdy}};
                trap_busy   = 1'b1;
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                redirect       = 1'b1;
                redirect_cause = cause_q;
                stage_ready    = {NUM_STAGES{prdy}};
                trap_busy      = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst_n) begin
            stage_ready    = '0;
            stage_flush    = '0;
            redirect       = 1'b0;
            redirect_cause = 2'b00;
            trap_busy      = 1'b0;
            stall_cnt_en   = 1'b0;
        end
    end

    // FSM state and latched trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Saturating count of hazard-stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_cnt_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Consecutive-stall watchdog; a limit of 0 keeps the counter at 0 and the error masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err   <= 1'b0;
        end else begin
            if (!stall_cnt_en) begin
                wdog_cnt_q <= '0;
            end else if (wdog_cnt_q != WDOG_MAX) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
            if ((WDOG_LIMIT != 0) && (wdog_cnt_q == WDOG_MAX)) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] stage_valid;
    logic       s_loaduse;
    logic       s_branch_jr_ok;
    logic       s_int;
    logic       s_syscall;
    logic       s_eret;

    logic [4:0]  stage_ready;
    logic [4:0]  stage_flush;
    logic        redirect;
    logic [1:0]  redirect_cause;
    logic        trap_busy;
    logic [31:0] stall_cycles;
    logic        wdog_err;

    logic [4:0]  sat_ready;
    logic [4:0]  sat_flush;
    logic        sat_redirect;
    logic [1:0]  sat_cause;
    logic        sat_busy;
    logic [1:0]  sat_stall_cycles;
    logic        sat_wdog_err;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(
        .NUM_STAGES(5), .STALL_STAGE(2), .TRAP_STAGE(1),
        .WDOG_LIMIT(4), .WDOG_WIDTH(8), .PERF_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stage_valid(stage_valid), .stage_ready(stage_ready), .stage_flush(stage_flush),
        .s_loaduse(s_loaduse), .s_branch_jr_ok(s_branch_jr_ok),
        .s_int(s_int), .s_syscall(s_syscall), .s_eret(s_eret),
        .redirect(redirect), .redirect_cause(redirect_cause), .trap_busy(trap_busy),
        .stall_cycles(stall_cycles), .wdog_err(wdog_err)
    );

    // Narrow perf counter, watchdog disabled: same stimulus, checks saturation.
    pipeline_hazard_ctrl #(
        .NUM_STAGES(5), .STALL_STAGE(2), .TRAP_STAGE(1),
        .WDOG_LIMIT(0), .WDOG_WIDTH(8), .PERF_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .stage_valid(stage_valid), .stage_ready(sat_ready), .stage_flush(sat_flush),
        .s_loaduse(s_loaduse), .s_branch_jr_ok(s_branch_jr_ok),
        .s_int(s_int), .s_syscall(s_syscall), .s_eret(s_eret),
        .redirect(sat_redirect), .redirect_cause(sat_cause), .trap_busy(sat_busy),
        .stall_cycles(sat_stall_cycles), .wdog_err(sat_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stage_valid    = 5'b11111;
        s_loaduse      = 1'b0;
        s_branch_jr_ok = 1'b1;
        s_int          = 1'b0;
        s_syscall      = 1'b0;
        s_eret         = 1'b0;
    endtask

    initial begin
        // Reset with random inputs: everything held low.
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            stage_valid    = 5'($urandom);
            s_loaduse      = 1'($urandom);
            s_branch_jr_ok = 1'($urandom);
            s_int          = 1'($urandom);
            s_syscall      = 1'($urandom);
            s_eret         = 1'($urandom);
            #2;
            check("rst_ready", 32'(stage_ready), 32'h0);
            check("rst_flush", 32'(stage_flush), 32'h0);
            check("rst_redirect", 32'({redirect, redirect_cause}), 32'h0);
            check("rst_busy", 32'(trap_busy), 32'h0);
            check("rst_stall_cycles", stall_cycles, 32'd0);
            check("rst_wdog", 32'(wdog_err), 32'h0);
            tick();
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(stage_ready), 32'h1f);
        check("idle_flush", 32'(stage_flush), 32'h0);
        tick();

        // Load-use for 3 cycles: younger stages hold, bubble into stage 2.
        s_loaduse = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lu_ready", 32'(stage_ready), 32'h1c);
            check("lu_flush", 32'(stage_flush), 32'h04);
            tick();
        end
        s_loaduse = 1'b0;
        #1;
        check("lu_stall_cycles", stall_cycles, 32'd3);
        check("lu_ready_release", 32'(stage_ready), 32'h1f);

        // Hazard while a stage is not done: nothing moves, bubble still requested, not counted.
        stage_valid = 5'b11011;
        s_loaduse   = 1'b1;
        #1;
        check("np_ready", 32'(stage_ready), 32'h0);
        check("np_flush", 32'(stage_flush), 32'h04);
        tick();
        check("np_stall_cycles", stall_cycles, 32'd3);
        idle_inputs();
        tick();

        // Syscall accepted, FLUSH cycle (trap inputs ignored), REDIRECT cycle.
        s_syscall = 1'b1;
        #1;
        check("sc_accept_flush", 32'(stage_flush), 32'h03);
        check("sc_accept_ready", 32'(stage_ready), 32'h1f);
        check("sc_accept_busy", 32'(trap_busy), 32'h0);
        tick();
        s_syscall = 1'b0;
        s_eret    = 1'b1;
        #1;
        check("sc_flush_flush", 32'(stage_flush), 32'h03);
        check("sc_flush_busy", 32'(trap_busy), 32'h1);
        check("sc_flush_redirect", 32'(redirect), 32'h0);
        tick();
        s_eret      = 1'b0;
        stage_valid = 5'b11110;
        #1;
        check("sc_redir_redirect", 32'({redirect, redirect_cause}), 32'h6);
        check("sc_redir_busy", 32'(trap_busy), 32'h1);
        check("sc_redir_flush", 32'(stage_flush), 32'h0);
        check("sc_redir_ready", 32'(stage_ready), 32'h0);
        tick();
        stage_valid = 5'b11111;
        #1;
        check("sc_done_redirect", 32'({redirect, redirect_cause}), 32'h0);
        check("sc_done_busy", 32'(trap_busy), 32'h0);

        // INT + ERET + load-use together: INT wins, no bubble, no stall counted.
        s_int     = 1'b1;
        s_eret    = 1'b1;
        s_loaduse = 1'b1;
        #1;
        check("int_flush", 32'(stage_flush), 32'h03);
        check("int_ready", 32'(stage_ready), 32'h1f);
        tick();
        idle_inputs();
        check("int_stall_cycles", stall_cycles, 32'd3);
        tick();
        check("int_redirect", 32'({redirect, redirect_cause}), 32'h5);
        tick();

        // Trap while a stage is not done is not accepted until all are done.
        stage_valid = 5'b11011;
        s_syscall   = 1'b1;
        #1;
        check("np_trap_flush", 32'(stage_flush), 32'h0);
        check("np_trap_ready", 32'(stage_ready), 32'h0);
        tick();
        check("np_trap_busy", 32'(trap_busy), 32'h0);
        stage_valid = 5'b11111;
        #1;
        check("np_trap_accept", 32'(stage_flush), 32'h03);
        tick();
        s_syscall = 1'b0;
        check("np_trap_busy2", 32'(trap_busy), 32'h1);
        tick();
        check("np_trap_redirect", 32'({redirect, redirect_cause}), 32'h6);
        tick();

        // Watchdog: 3 stalls do not trip it, 4 do, and it stays set.
        s_branch_jr_ok = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        s_branch_jr_ok = 1'b1;
        tick();
        tick();
        check("wd_short", 32'(wdog_err), 32'h0);
        check("wd_short_cycles", stall_cycles, 32'd6);
        s_branch_jr_ok = 1'b0;
        #1;
        check("br_ready", 32'(stage_ready), 32'h1c);
        for (int i = 0; i < 4; i++) tick();
        s_branch_jr_ok = 1'b1;
        tick();
        check("wd_set", 32'(wdog_err), 32'h1);
        tick();
        tick();
        check("wd_sticky", 32'(wdog_err), 32'h1);
        check("wd_cycles", stall_cycles, 32'd10);
        check("sat_cycles", 32'(sat_stall_cycles), 32'd3);
        check("sat_wdog_off", 32'(sat_wdog_err), 32'h0);

        // Reset in FLUSH aborts the trap with no redirect and clears counters.
        s_int = 1'b1;
        tick();
        s_int = 1'b0;
        check("ab_busy", 32'(trap_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ab_rst_busy", 32'(trap_busy), 32'h0);
        check("ab_rst_wdog", 32'(wdog_err), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ab_redirect", 32'(redirect), 32'h0);
        tick();
        check("ab_redirect2", 32'(redirect), 32'h0);
        check("ab_busy2", 32'(trap_busy), 32'h0);
        check("ab_cycles", stall_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
